pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, 2..16).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_ack  input  1  instruction memory accepts the fetch at pc_out.
REQ-006 stall  input  1  hold current EXEC cycle; no PC/stack update.
REQ-007 next_valid  input  1  current instruction is a jump/branch; next_pc is the resolved target.
REQ-008 next_pc  input  16  resolved next PC from the displacement unit (taken target or pc+1).
REQ-009 call  input  1  push pc_out+1 to stack, then load next_pc.
REQ-010 ret  input  1  pop stack top into PC.
REQ-011 flags_we  input  1  latch flags_in into the flag register.
REQ-012 flags_in  input  8  ALU flags; bit 6 = zero/equal, bit 7 = greater/compare.
REQ-013 pc_out  output  16  current program counter.
REQ-014 flags_out  output  8  registered flags, fed to the displacement unit.
REQ-015 fetch_req  output  1  request instruction fetch at pc_out.
REQ-016 ras_empty  output  1  stack holds zero entries.
REQ-017 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-018 ras_error  output  1  sticky stack overflow/underflow indicator.

Function
REQ-019 FSM states FETCH, EXEC, HALT; state is registered; no other state reachable.
REQ-020 FETCH: fetch_req=1; on fetch_ack=1 go to EXEC next cycle; otherwise remain, pc_out unchanged.
REQ-021 EXEC: fetch_req=0; if stall=1 remain EXEC with no PC, stack, or state change.
REQ-022 EXEC, stall=0: apply exactly one PC update by priority ret > call > next_valid > increment, then go to FETCH.
REQ-023 ret: pc_out <= stack top, depth decrements; call ignored when both asserted same cycle.
REQ-024 call: stack top <= pc_out+1 (mod 2^16), depth increments, pc_out <= next_pc.
REQ-025 next_valid only: pc_out <= next_pc.
REQ-026 None asserted: pc_out <= pc_out+1, 16-bit wrap, 16'hFFFF -> 16'h0000.
REQ-027 ret with stack empty (underflow) or call with stack full (overflow): pc_out and stack unchanged, ras_error <= 1, state -> HALT.
REQ-028 HALT: fetch_req=0, pc_out and stack frozen, all inputs except reset and flags_we ignored; exit only by reset.
REQ-029 call, ret, next_valid, and stall are sampled only in EXEC; ignored in FETCH and HALT.
REQ-030 flags_we=1 in any state: flags_out <= flags_in next edge (1-cycle latency); flags_we=0 holds flags_out.
REQ-031 ras_empty/ras_full are decoded from the registered depth count and update the cycle after a push/pop.
REQ-032 Stack is LIFO; a push after a pop overwrites the popped slot; no storage reset required beyond the depth count.

Reset
REQ-033 reset=1 at an edge: pc_out=RESET_PC, state=FETCH, depth=0, ras_empty=1, ras_full=0, ras_error=0, flags_out=8'h00.
REQ-034 fetch_req is forced 0 while reset=1; fetch_ack is ignored while reset=1.
REQ-035 reset overrides every other input in the same cycle, including mid-EXEC, mid-stall, and HALT.

Verification
REQ-036 Reset, then 3 fetch_ack pulses with no controls -> pc_out 0,1,2,3; fetch_req drops for exactly one EXEC cycle each.
REQ-037 pc_out=16'h0010, call, next_pc=16'h0100 -> pc_out=16'h0100, ras_empty=0; later ret -> pc_out=16'h0011, ras_empty=1.
REQ-038 RAS_DEPTH=4: 4 nested calls -> ras_full=1; 5th call -> ras_error=1, HALT, pc_out unchanged, fetch_req=0 until reset.
REQ-039 ret on empty stack -> ras_error=1, HALT; reset -> pc_out=RESET_PC, ras_error=0, fetch_req=1 the cycle after reset drops.
REQ-040 Stall held 3 cycles in EXEC with next_valid=1, next_pc=16'h0040 -> pc_out unchanged during stall, 16'h0040 after release; pc_out=16'hFFFF increment -> 16'h0000.
REQ-041 flags_we=1, flags_in=8'h40 -> flags_out=8'h40 next cycle; simultaneous call+ret in EXEC -> pop only, depth -1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: FETCH/EXEC/HALT control, return-address stack,
// and the flag register feeding the displacement unit.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ack,
    input  logic        stall,
    input  logic        next_valid,
    input  logic [15:0] next_pc,
    input  logic        call,
    input  logic        ret,
    input  logic        flags_we,
    input  logic [7:0]  flags_in,
    output logic [15:0] pc_out,
    output logic [7:0]  flags_out,
    output logic        fetch_req,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_error
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t                          state_q, state_d;
    logic [15:0]                     pc_q, pc_d;
    logic [7:0]                      flags_q, flags_d;
    logic [DW-1:0]                   depth_q, depth_d;
    logic                            err_q, err_d;
    logic                            fetch_req_q, fetch_req_d;
    logic [RAS_DEPTH-1:0][15:0]      stack_q, stack_d;
    logic [AW-1:0]                   top_idx;
    logic [AW-1:0]                   push_idx;
    logic                            empty, full;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DW'(RAS_DEPTH));
    assign top_idx  = AW'(depth_q - DW'(1));
    assign push_idx = AW'(depth_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        stack_d = stack_q;
        flags_d = flags_we ? flags_in : flags_q;
        case (state_q)
            FETCH: if (fetch_ack) state_d = EXEC;
            EXEC: begin
                if (!stall) begin
                    state_d = FETCH;
                    // ret wins over call; a faulting stack op freezes PC and stack
                    if (ret) begin
                        if (empty) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d    = stack_q[top_idx];
                            depth_d = depth_q - DW'(1);
                        end
                    end else if (call) begin
                        if (full) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            stack_d[push_idx] = pc_q + 16'd1;
                            depth_d = depth_q + DW'(1);
                            pc_d    = next_pc;
                        end
                    end else if (next_valid) begin
                        pc_d = next_pc;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            default: state_d = HALT;
        endcase
        fetch_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            depth_q     <= '0;
            err_q       <= 1'b0;
            flags_q     <= 8'h00;
            fetch_req_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            flags_q     <= flags_d;
            fetch_req_q <= fetch_req_d;
        end
    end

    // Stack storage carries no reset; only the depth count defines validity.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc_out    = pc_q;
    assign flags_out = flags_q;
    assign fetch_req = fetch_req_q & ~reset;
    assign ras_empty = empty;
    assign ras_full  = full;
    assign ras_error = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
    logic        clk, reset, fetch_ack, stall, next_valid, call, ret, flags_we;
    logic [15:0] next_pc, pc_out;
    logic [7:0]  flags_in, flags_out;
    logic        fetch_req, ras_empty, ras_full, ras_error;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .fetch_ack(fetch_ack), .stall(stall),
        .next_valid(next_valid), .next_pc(next_pc), .call(call), .ret(ret),
        .flags_we(flags_we), .flags_in(flags_in), .pc_out(pc_out),
        .flags_out(flags_out), .fetch_req(fetch_req), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_error(ras_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch handshake followed by one non-stalled EXEC cycle.
    task automatic instr(input logic c, input logic r, input logic nv, input logic [15:0] npc);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        call = c; ret = r; next_valid = nv; next_pc = npc;
        step();
        call = 1'b0; ret = 1'b0; next_valid = 1'b0; next_pc = 16'h0000;
    endtask

    initial begin
        reset = 1'b1; fetch_ack = 1'b0; stall = 1'b0; next_valid = 1'b0;
        call = 1'b0; ret = 1'b0; flags_we = 1'b0; next_pc = 16'h0; flags_in = 8'h0;
        step();
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_fetch_req", fetch_req, 1'b0);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_err", ras_error, 1'b0);
        chk("rst_flags", flags_out, 8'h00);
        reset = 1'b0;
        #1;
        chk("post_rst_req", fetch_req, 1'b1);
        step();
        chk("fetch_wait_pc", pc_out, 16'h0000);
        chk("fetch_wait_req", fetch_req, 1'b1);

        // Sequential fetches: one EXEC cycle each with fetch_req low
        for (int i = 0; i < 3; i++) begin
            fetch_ack = 1'b1;
            step();
            fetch_ack = 1'b0;
            chk("exec_req_low", fetch_req, 1'b0);
            step();
            chk("seq_req_high", fetch_req, 1'b1);
            chk("seq_pc", pc_out, 32'(i + 1));
        end

        instr(1'b0, 1'b0, 1'b1, 16'h0010);
        chk("jump_pc", pc_out, 16'h0010);
        instr(1'b1, 1'b0, 1'b0, 16'h0100);
        chk("call_pc", pc_out, 16'h0100);
        chk("call_empty", ras_empty, 1'b0);
        instr(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("ret_pc", pc_out, 16'h0011);
        chk("ret_empty", ras_empty, 1'b1);

        // call+ret together pops only
        instr(1'b1, 1'b0, 1'b0, 16'h0200);
        instr(1'b1, 1'b0, 1'b0, 16'h0300);
        chk("nest_pc", pc_out, 16'h0300);
        instr(1'b1, 1'b1, 1'b0, 16'h0500);
        chk("callret_pc", pc_out, 16'h0201);
        chk("callret_empty", ras_empty, 1'b0);
        instr(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("callret_pop2", pc_out, 16'h0012);
        chk("callret_empty2", ras_empty, 1'b1);

        flags_we = 1'b1; flags_in = 8'h40;
        step();
        flags_we = 1'b0; flags_in = 8'h99;
        chk("flags_we", flags_out, 8'h40);
        step();
        chk("flags_hold", flags_out, 8'h40);

        // Stall holds PC for three cycles
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        stall = 1'b1; next_valid = 1'b1; next_pc = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_out, 16'h0012);
            chk("stall_req", fetch_req, 1'b0);
        end
        stall = 1'b0;
        step();
        next_valid = 1'b0;
        chk("stall_rel_pc", pc_out, 16'h0040);
        chk("stall_rel_req", fetch_req, 1'b1);

        instr(1'b0, 1'b0, 1'b1, 16'hFFFF);
        chk("pre_wrap", pc_out, 16'hFFFF);
        instr(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("wrap", pc_out, 16'h0000);

        // Overflow
        instr(1'b1, 1'b0, 1'b0, 16'h1000);
        instr(1'b1, 1'b0, 1'b0, 16'h2000);
        instr(1'b1, 1'b0, 1'b0, 16'h3000);
        chk("not_full3", ras_full, 1'b0);
        instr(1'b1, 1'b0, 1'b0, 16'h4000);
        chk("full4", ras_full, 1'b1);
        chk("full4_pc", pc_out, 16'h4000);
        instr(1'b1, 1'b0, 1'b0, 16'h5000);
        chk("ovf_pc", pc_out, 16'h4000);
        chk("ovf_err", ras_error, 1'b1);
        chk("ovf_req", fetch_req, 1'b0);
        fetch_ack = 1'b1; next_valid = 1'b1; next_pc = 16'h7777; ret = 1'b1;
        flags_we = 1'b1; flags_in = 8'h80;
        step(); step();
        fetch_ack = 1'b0; next_valid = 1'b0; ret = 1'b0; flags_we = 1'b0;
        chk("halt_pc", pc_out, 16'h4000);
        chk("halt_req", fetch_req, 1'b0);
        chk("halt_full", ras_full, 1'b1);
        chk("halt_flags", flags_out, 8'h80);

        reset = 1'b1;
        step();
        chk("rst2_pc", pc_out, 16'h0000);
        chk("rst2_err", ras_error, 1'b0);
        chk("rst2_empty", ras_empty, 1'b1);
        chk("rst2_flags", flags_out, 8'h00);
        reset = 1'b0;
        #1;
        chk("rst2_req", fetch_req, 1'b1);

        // Underflow
        instr(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("unf_err", ras_error, 1'b1);
        chk("unf_pc", pc_out, 16'h0000);
        chk("unf_req", fetch_req, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst3_err", ras_error, 1'b0);
        chk("rst3_req", fetch_req, 1'b1);

        // Reset mid-stall returns to FETCH at RESET_PC
        instr(1'b0, 1'b0, 1'b1, 16'h0123);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0; stall = 1'b1; reset = 1'b1;
        step();
        stall = 1'b0; reset = 1'b0;
        #1;
        chk("rst_stall_pc", pc_out, 16'h0000);
        chk("rst_stall_req", fetch_req, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
